// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one shared resource: one-hot grant plus binary mux select.
// A grant is held until done, request drop, or watchdog expiry, with back-to-back handover.
module rr_arbiter #(
    parameter int P_REQUESTERS = 4,
    parameter int P_TIMEOUT    = 16
) (
    input  logic                            I_CLK,
    input  logic                            I_NRESET,
    input  logic [P_REQUESTERS-1:0]         I_REQ,
    input  logic                            I_DONE,
    output logic [P_REQUESTERS-1:0]         O_GRANT,
    output logic [$clog2(P_REQUESTERS)-1:0] O_SELECT,
    output logic                            O_BUSY,
    output logic                            O_TIMEOUT
);

    localparam int SW        = $clog2(P_REQUESTERS);
    localparam int CW        = (P_TIMEOUT == 0) ? 1 : $clog2(P_TIMEOUT + 1);
    localparam int TO_LAST_I = (P_TIMEOUT == 0) ? 0 : P_TIMEOUT - 1;

    localparam logic [CW-1:0]           TO_LAST = CW'(TO_LAST_I);
    localparam logic [P_REQUESTERS-1:0] ONE     = P_REQUESTERS'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t                  state_q,   state_d;
    logic [SW-1:0]           ptr_q,     ptr_d;
    logic [CW-1:0]           cnt_q,     cnt_d;
    logic [P_REQUESTERS-1:0] grant_q,   grant_d;
    logic [SW-1:0]           sel_q,     sel_d;
    logic                    timeout_q, timeout_d;

    logic [P_REQUESTERS-1:0] owner_mask;
    logic [P_REQUESTERS-1:0] elig;
    logic [SW-1:0]           next_ptr;
    logic [SW-1:0]           base;
    logic [SW-1:0]           win;
    logic                    owner_req;
    logic                    normal_rel;
    logic                    timeout_hit;
    logic                    found;
    int                      idx;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        owner_mask  = ONE << sel_q;
        owner_req   = |(I_REQ & owner_mask);
        normal_rel  = I_DONE || !owner_req;
        timeout_hit = (P_TIMEOUT != 0) && (state_q == S_GRANTED) &&
                      (cnt_q == TO_LAST) && !normal_rel;
        next_ptr    = (int'(sel_q) == P_REQUESTERS - 1) ? '0 : sel_q + SW'(1);

        // From IDLE scan from the stored pointer; on release scan from just past the owner.
        base = (state_q == S_IDLE) ? ptr_q : next_ptr;
        elig = timeout_hit ? (I_REQ & ~owner_mask) : I_REQ;

        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int off = 0; off < P_REQUESTERS; off++) begin
            idx = int'(base) + off;
            if (idx >= P_REQUESTERS) begin
                idx = idx - P_REQUESTERS;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end

        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANTED;
                    grant_d = ONE << win;
                    sel_d   = win;
                    cnt_d   = '0;
                end
            end
            S_GRANTED: begin
                if (normal_rel || timeout_hit) begin
                    ptr_d     = next_ptr;
                    timeout_d = timeout_hit;
                    cnt_d     = '0;
                    if (found) begin
                        grant_d = ONE << win;
                        sel_d   = win;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    assign O_GRANT   = grant_q;
    assign O_SELECT  = sel_q;
    assign O_BUSY    = (state_q == S_GRANTED);
    assign O_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed steps then random traffic against a behavioural model.
// A second instance (3 requesters, watchdog disabled) checks the no-timeout configuration.
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic         done  = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   sel;
    logic         busy;
    logic         tout;

    logic [2:0]   req3  = '0;
    logic         done3 = 1'b0;
    logic [2:0]   grant3;
    logic [1:0]   sel3;
    logic         busy3;
    logic         tout3;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 when idle), pointer, hold count, last select, timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_sel   = 0;
    int m_to    = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.P_REQUESTERS(N), .P_TIMEOUT(TO)) u_dut (
        .I_CLK     (clk),
        .I_NRESET  (rst_n),
        .I_REQ     (req),
        .I_DONE    (done),
        .O_GRANT   (grant),
        .O_SELECT  (sel),
        .O_BUSY    (busy),
        .O_TIMEOUT (tout)
    );

    rr_arbiter #(.P_REQUESTERS(3), .P_TIMEOUT(0)) u_dut3 (
        .I_CLK     (clk),
        .I_NRESET  (rst_n),
        .I_REQ     (req3),
        .I_DONE    (done3),
        .O_GRANT   (grant3),
        .O_SELECT  (sel3),
        .O_BUSY    (busy3),
        .O_TIMEOUT (tout3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int base, input int skip);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (base + k) % N;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_sel   = 0;
        m_to    = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        int w;
        bit normal;
        bit expire;
        m_to = 0;
        if (m_owner < 0) begin
            if (r != 0) begin
                w       = pick(r, m_ptr, -1);
                m_owner = w;
                m_sel   = w;
                m_cnt   = 0;
            end
        end else begin
            normal = d || !r[m_owner];
            expire = (TO != 0) && (m_cnt == TO - 1) && !normal;
            if (normal || expire) begin
                m_ptr = (m_owner + 1) % N;
                m_to  = expire ? 1 : 0;
                w     = pick(r, m_ptr, expire ? m_owner : -1);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = w;
                    m_cnt   = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_grant"},   32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check({tag, "_select"},  32'(sel),   32'(m_sel));
        check({tag, "_busy"},    32'(busy),  (m_owner < 0) ? 32'd0 : 32'd1);
        check({tag, "_timeout"}, 32'(tout),  32'(m_to));
    endtask

    // Drive inputs, take one rising edge, advance the model, sample 1 time unit later.
    task automatic cycle(input logic [N-1:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int to_pulses;

        // 1. Reset holds everything at zero even with all requests active.
        req = 4'b1111;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset");
        check("reset3_grant", 32'(grant3), 32'd0);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req = 4'b0100;
        #1;
        check("latency_no_comb_grant", 32'(grant), 32'd0);
        cycle(4'b0100, 1'b0, "first_grant");
        check("first_grant_sel2", 32'(sel), 32'd2);

        // 2. Back-to-back rotation with done every cycle.
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1, "rotate");
            check("rotate_busy_held", 32'(busy), 32'd1);
        end

        // 3. Wrap from pointer 3 to requester 0, then handover when owner drops.
        cycle(4'b0100, 1'b1, "to_owner2");
        cycle(4'b0011, 1'b1, "wrap");
        check("wrap_grant0", 32'(grant), 32'b0001);
        cycle(4'b0010, 1'b0, "drop");
        check("drop_grant1", 32'(grant), 32'b0010);

        // 4. Watchdog: lone requester 1 holds without done.
        to_pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(4'b0010, 1'b0, "wdog");
            if (tout === 1'b1) to_pulses++;
        end
        check("wdog_pulse_count", 32'(to_pulses), 32'd1);
        check("wdog_idle_grant", 32'(grant), 32'd0);
        check("wdog_idle_sel", 32'(sel), 32'd1);
        cycle(4'b0010, 1'b0, "wdog_regrant");
        check("wdog_pulse_cleared", 32'(tout), 32'd0);
        for (int i = 0; i < 15; i++) cycle(4'b0010, 1'b0, "wdog2_hold");
        cycle(4'b0010, 1'b1, "wdog2_done");
        check("done_beats_timeout", 32'(tout), 32'd0);
        check("done_regrant_owner1", 32'(grant), 32'b0010);

        // 5. Asynchronous reset between edges while requester 3 owns.
        cycle(4'b1000, 1'b1, "to_owner3");
        check("owner3_grant", 32'(grant), 32'b1000);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        #2 rst_n = 1'b1;
        cycle(4'b1001, 1'b0, "post_reset");
        check("post_reset_grant0", 32'(grant), 32'b0001);

        // 6. Three requesters, watchdog disabled: ownership never moves.
        req3 = 3'b111;
        for (int i = 0; i < 100; i++) begin
            cycle(4'b0000, 1'b0, "idle_side");
            check("nowd_grant", 32'(grant3), 32'b001);
            check("nowd_select", 32'(sel3), 32'd0);
            check("nowd_timeout", 32'(tout3), 32'd0);
        end
        req3 = 3'b000;

        // Random traffic, alternating churn-heavy and hold-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            logic d;
            if (((i / 200) % 2) == 0) begin
                r = N'($urandom);
                d = ($urandom_range(3) == 0);
            end else begin
                r = N'($urandom | $urandom | $urandom);
                d = ($urandom_range(31) == 0);
            end
            cycle(r, d, "rand");
            check("rand_onehot", 32'($countones(grant) <= 1), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one datapath resource (memory port, shared bus) among P_REQUESTERS masters.
- Produces a one-hot grant for the masters and a binary select that drives the mux selecting the owner's signals onto the resource.
- Ownership is held until the owner signals completion, drops its request, or a watchdog timeout fires.
- Sits between the CPU/DMA/IO masters and the shared-resource mux in the top-level datapath.

Parameters:
- P_REQUESTERS, 4, number of requesters. Must be >= 2; non-power-of-2 values allowed.
- P_TIMEOUT, 16, maximum cycles a grant is held without I_DONE. 0 disables the watchdog.

Ports:
- I_CLK  input  1  system clock, rising edge.
- I_NRESET  input  1  asynchronous, active-low reset.
- I_REQ  input  P_REQUESTERS  per-master request; bit i = master i.
- I_DONE  input  1  owner's transaction complete; sampled only in GRANTED.
- O_GRANT  output  P_REQUESTERS  one-hot grant, registered.
- O_SELECT  output  $clog2(P_REQUESTERS)  binary index of owner, for the mux select input.
- O_BUSY  output  1  high while any grant is active.
- O_TIMEOUT  output  1  one-cycle pulse on watchdog-forced release.

Behaviour:
- Reset (I_NRESET=0, asynchronous, any time including mid-grant):
  - state=IDLE, O_GRANT=0, O_SELECT=0, O_BUSY=0, O_TIMEOUT=0.
  - Priority pointer=0; hold counter=0.
- States are IDLE and GRANTED; O_BUSY = (state==GRANTED), registered.
- Arbitration:
  - Choose the first set I_REQ bit scanning from the pointer upward, wrapping modulo P_REQUESTERS.
  - The winner's index goes to O_SELECT and its bit to O_GRANT.
- IDLE:
  - If I_REQ != 0 at edge N, arbitrate, enter GRANTED, reset the counter to 0.
  - Grant is visible after edge N (1-cycle latency).
  - I_DONE is ignored.
- GRANTED:
  - O_GRANT and O_SELECT are stable; I_REQ changes of non-owners have no effect.
  - Counter increments each cycle and saturates.
- Release occurs at an edge where any of the following holds:
  - (a) I_DONE=1.
  - (b) I_REQ[owner]=0.
  - (c) P_TIMEOUT!=0 and counter==P_TIMEOUT-1 without (a)/(b). O_TIMEOUT=1 for the following cycle only.
- On release:
  - Pointer becomes (owner+1) mod P_REQUESTERS.
  - Re-arbitrate in the same edge using the new pointer: if any eligible request exists, stay GRANTED with the new winner, counter=0 (back-to-back, no bubble). Otherwise go to IDLE with O_GRANT=0.
  - Eligible means I_REQ, except that on a timeout release the timed-out owner is masked out for that single arbitration.
  - After a normal (a)/(b) release the old owner may be re-granted if it is the only requester.
- Simultaneous conditions: (a) and (b) together count as a single normal release. (a) or (b) in the same cycle as the timeout boundary takes precedence, so O_TIMEOUT=0.
- O_SELECT holds the last owner in IDLE, so the mux output stays stable; it only changes when a new grant is issued.
- O_GRANT is always one-hot or zero; never more than one bit set.
- Counter width is $clog2(P_TIMEOUT+1), minimum 1.

Test Plan:
1. Reset/idle: hold I_NRESET=0 with I_REQ=4'b1111 -> all outputs 0. Release reset, I_REQ=4'b0100 -> one edge later O_GRANT=0100, O_SELECT=2, O_BUSY=1.
2. Round-robin fairness, back-to-back: I_REQ=4'b1111, pulse I_DONE each cycle the grant is active.
   -> Grants in order 0001, 0010, 0100, 1000, 0001, one per handover, no IDLE bubble.
   -> O_BUSY stays 1 throughout.
3. Wrap and skip: pointer=3 (after owner 2 releases), I_REQ=4'b0011 -> grant 0001, O_SELECT=0. Owner drops I_REQ[0] -> grant 0010 next edge.
4. Timeout, P_TIMEOUT=16: single requester I_REQ=4'b0010, never assert I_DONE.
   -> Release after 16 GRANTED cycles, O_TIMEOUT=1 for exactly 1 cycle.
   -> Owner is masked out, so the arbiter goes to IDLE (O_GRANT=0, O_SELECT=1). Requester 1 is re-granted one edge later.
   -> Repeat with I_DONE on cycle 16 -> O_TIMEOUT stays 0.
5. Async reset mid-grant: assert I_NRESET=0 between clock edges while O_GRANT=1000 -> outputs clear immediately without a clock edge. After reset, I_REQ=4'b1001 -> grant 0001 (pointer back to 0).
6. P_REQUESTERS=3, P_TIMEOUT=0: I_REQ=3'b111 with no I_DONE held for 100 cycles -> grant 001 never changes, O_TIMEOUT never asserts, O_SELECT is 2 bits wide.
